// File: rtl/duc_interpolator.sv
// duc_interpolator: transmit-side digital up-converter.
// Complex baseband I/Q enters at clk/R through a valid/ready handshake into a
// 2-entry FIFO, is interpolated by R = 2^RLOG2 with a 3-stage CIC per rail,
// mixed to +fs/4 with a multiplier-free quadrature LO and emitted as one
// offset-binary DAC word per clk.
// Build option: define DUC_ROUND_EN to round-half-up with saturation at the CIC
// trim; left undefined, the trim is plain truncation.
// RLOG2 must be >= 2 so that R is a multiple of 4 and the LO phase lines up with
// every rate tick.
module duc_interpolator #(
  parameter int ISZ   = 16,
  parameter int RLOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [ISZ-1:0] in_i,
  input  logic signed [ISZ-1:0] in_q,
  output logic        [ISZ-1:0] out,
  output logic                  out_underflow
);

  // CIC order is fixed; the trim position and bit growth below depend on it.
  localparam int N = 3;
  localparam int W = ISZ + (N - 1) * RLOG2;

  localparam logic signed [ISZ-1:0] S_MAX = {1'b0, {(ISZ-1){1'b1}}};
  localparam logic signed [ISZ-1:0] S_MIN = {1'b1, {(ISZ-1){1'b0}}};

  function automatic logic signed [W-1:0] sext(input logic signed [ISZ-1:0] v);
    return {{(W-ISZ){v[ISZ-1]}}, v};
  endfunction

  function automatic logic signed [ISZ-1:0] sat_neg(input logic signed [ISZ-1:0] v);
    return (v == S_MIN) ? S_MAX : -v;
  endfunction

  // ---------------------------------------------------------------------------
  // Rate divider and LO phase
  // ---------------------------------------------------------------------------
  logic [RLOG2-1:0] div_cnt;
  logic [1:0]       lo_phase;
  logic             tick;

  // The counter wraps naturally at R-1; tick marks the last cycle of each period.
  assign tick = &div_cnt;

  // Divider and LO phase both start at 0, so the phase wraps to 0 on every pop edge.
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt  <= '0;
      lo_phase <= '0;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
      lo_phase <= lo_phase + 2'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // 2-entry input FIFO
  // ---------------------------------------------------------------------------
  logic signed [ISZ-1:0] fifo_i [2];
  logic signed [ISZ-1:0] fifo_q [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            fifo_cnt;
  logic                  empty;
  logic                  push;
  logic                  pop;

  assign empty    = (fifo_cnt == 2'd0);
  assign in_ready = (fifo_cnt != 2'd2);
  assign push     = in_valid & in_ready;
  assign pop      = tick & ~empty;

  // Sample storage is written on push only.
  // NOTE: the storage array has no reset; the pointers and count decide which
  // entries are valid, so clearing the data would buy nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_i[wr_ptr] <= in_i;
      fifo_q[wr_ptr] <= in_q;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push/pop leaves the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  // ---------------------------------------------------------------------------
  // CIC interpolator, rail 0 = I, rail 1 = Q
  // A popped sample passes six registers on its way to out:
  // x_reg -> stuff -> int1 -> int2 -> int3 -> out.
  // ---------------------------------------------------------------------------
  logic                tick_d;
  logic signed [W-1:0] x_reg [2];
  logic signed [W-1:0] dly1  [2];
  logic signed [W-1:0] dly2  [2];
  logic signed [W-1:0] dly3  [2];
  logic signed [W-1:0] c1    [2];
  logic signed [W-1:0] c2    [2];
  logic signed [W-1:0] c3    [2];
  logic signed [W-1:0] stuff [2];
  logic signed [W-1:0] int1  [2];
  logic signed [W-1:0] int2  [2];
  logic signed [W-1:0] int3  [2];

  // Pop the FIFO head (or zeros on underflow) into the comb input register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_d        <= 1'b0;
      out_underflow <= 1'b0;
      x_reg[0]      <= '0;
      x_reg[1]      <= '0;
    end else begin
      tick_d        <= tick;
      out_underflow <= tick & empty;
      if (tick) begin
        x_reg[0] <= empty ? '0 : sext(fifo_i[rd_ptr]);
        x_reg[1] <= empty ? '0 : sext(fifo_q[rd_ptr]);
      end
    end
  end

  // Comb chain (M = 1) as combinational differences against the delay registers.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
      c1[r] = x_reg[r] - dly1[r];
      c2[r] = c1[r]    - dly2[r];
      c3[r] = c2[r]    - dly3[r];
    end
  end

  // Combs advance once per input sample (the cycle after the pop); the zero
  // stuffer passes their result for that one cycle and zero for the other R-1.
  // Integrators run every clk and wrap at W bits by design.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < 2; r++) begin
        dly1[r]  <= '0;
        dly2[r]  <= '0;
        dly3[r]  <= '0;
        stuff[r] <= '0;
        int1[r]  <= '0;
        int2[r]  <= '0;
        int3[r]  <= '0;
      end
    end else begin
      for (int r = 0; r < 2; r++) begin
        if (tick_d) begin
          dly1[r] <= x_reg[r];
          dly2[r] <= c1[r];
          dly3[r] <= c2[r];
        end
        stuff[r] <= tick_d ? c3[r] : '0;
        int1[r]  <= int1[r] + stuff[r];
        int2[r]  <= int2[r] + int1[r];
        int3[r]  <= int3[r] + int2[r];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Trim to ISZ bits (DC gain R^(N-1) removed), fs/4 mix, offset-binary output
  // ---------------------------------------------------------------------------
  logic signed [ISZ-1:0] trimmed [2];
  logic signed [ISZ-1:0] mixed;
`ifdef DUC_ROUND_EN
  logic        [ISZ:0]   rnd [2];
`endif

  // Trim each rail; rounding adds the first discarded bit, which equals adding
  // half an output LSB before truncation.
  // NOTE: every branch of a combinational block assigns its outputs, otherwise
  // synthesis would infer a latch to hold the old value.
  always_comb begin
    for (int r = 0; r < 2; r++) begin
`ifdef DUC_ROUND_EN
      rnd[r] = {int3[r][W-1], int3[r][W-1 -: ISZ]} + {{ISZ{1'b0}}, int3[r][W-ISZ-1]};
      if (rnd[r][ISZ] != rnd[r][ISZ-1]) begin
        trimmed[r] = rnd[r][ISZ] ? S_MIN : S_MAX;
      end else begin
        trimmed[r] = rnd[r][ISZ-1:0];
      end
`else
      trimmed[r] = int3[r][W-1 -: ISZ];
`endif
    end
  end

  // Quadrature LO at fs/4: the sequence cos/-sin only ever takes 0, +1, -1.
  always_comb begin
    unique case (lo_phase)
      2'd0:    mixed = trimmed[0];
      2'd1:    mixed = sat_neg(trimmed[1]);
      2'd2:    mixed = sat_neg(trimmed[0]);
      default: mixed = trimmed[1];
    endcase
  end

  // Register the DAC word; flipping the MSB converts two's complement to offset binary.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out <= {1'b1, {(ISZ-1){1'b0}}};
    end else begin
      out <= {~mixed[ISZ-1], mixed[ISZ-2:0]};
    end
  end

endmodule

// File: tb/tb_duc_interpolator.sv
// tb_duc_interpolator: directed self-checking bench for duc_interpolator
// (ISZ = 16, R = 32). Edge numbers count rising clk edges after reset release;
// the first pop happens on edge 32 and every 32nd edge after that.
`timescale 1ns/1ps
module tb_duc_interpolator;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic        [15:0] out;
  logic               out_underflow;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  // Settled DC sequences indexed by the LO phase that produced each word.
  localparam logic [15:0] DC_I_SEQ [4] = '{16'h83E8, 16'h8000, 16'h7C18, 16'h8000};
  localparam logic [15:0] DC_Q_SEQ [4] = '{16'h8000, 16'h87D0, 16'h8000, 16'h7830};
  localparam logic [15:0] SAT_SEQ  [4] = '{16'h0000, 16'h8000, 16'hFFFF, 16'h8000};

  duc_interpolator #(.ISZ(16), .RLOG2(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_i         (in_i),
    .in_q         (in_q),
    .out          (out),
    .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  // Advance n rising edges, then settle on the following falling edge.
  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      edge_n++;
    end
    @(negedge clk);
  endtask

  task automatic goto_edge(input int k);
    if (k > edge_n) adv(k - edge_n);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
    reset    = 1'b0;
    repeat (10) @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
  endtask

  // The word after edge k was built from LO phase (k-1) mod 4.
  task automatic check_seq(input string name, input int first, input int last,
                           input logic [15:0] s0, input logic [15:0] s1,
                           input logic [15:0] s2, input logic [15:0] s3);
    logic [1:0]  ph;
    logic [15:0] exp_v;
    for (int k = first; k <= last; k++) begin
      goto_edge(k);
      ph = 2'(k - 1);
      case (ph)
        2'd0:    exp_v = s0;
        2'd1:    exp_v = s1;
        2'd2:    exp_v = s2;
        default: exp_v = s3;
      endcase
      n_tests++;
      if (out !== exp_v) begin
        n_fail++;
        $display("FAIL %s edge %0d: out=%h expected %h", name, k, out, exp_v);
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_i     = '0;
    in_q     = '0;
    reset    = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++;
    if (out !== 16'h8000) begin
      n_fail++; $display("FAIL reset_out: out=%h expected 8000", out);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: in_ready=%b expected 1", in_ready);
    end
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_uf: out_underflow=%b expected 0", out_underflow);
    end
    reset  = 1'b1;
    edge_n = 0;
    // Empty FIFO: the first tick must show up as an underflow pulse on edge 32.
    goto_edge(31);
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL first_tick_e31: out_underflow=%b expected 0", out_underflow);
    end
    goto_edge(32);
    n_tests++;
    if (out_underflow !== 1'b1) begin
      n_fail++; $display("FAIL first_tick_e32: out_underflow=%b expected 1", out_underflow);
    end
    goto_edge(33);
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL first_tick_e33: out_underflow=%b expected 0", out_underflow);
    end
  endtask

  task automatic test_dc_i();
    apply_reset();
    in_i     = 16'sd1000;
    in_q     = 16'sd0;
    in_valid = 1'b1;
    check_seq("dc_i", 160, 167, DC_I_SEQ[0], DC_I_SEQ[1], DC_I_SEQ[2], DC_I_SEQ[3]);
    in_valid = 1'b0;
  endtask

  task automatic test_dc_q();
    apply_reset();
    in_i     = 16'sd0;
    in_q     = -16'sd2000;
    in_valid = 1'b1;
    check_seq("dc_q", 160, 167, DC_Q_SEQ[0], DC_Q_SEQ[1], DC_Q_SEQ[2], DC_Q_SEQ[3]);
    in_valid = 1'b0;
  endtask

  // Sample 0 = (1024, 0), sample 1 = (0, 1024), then zeros, valid held high.
  task automatic test_handshake();
    int pushes = 0;
    apply_reset();
    in_valid = 1'b1;
    while (edge_n < 31) begin
      in_i = (pushes == 0) ? 16'sd1024 : 16'sd0;
      in_q = (pushes == 1) ? 16'sd1024 : 16'sd0;
      if (in_ready) pushes++;
      adv(1);
    end
    n_tests++;
    if (pushes != 2) begin
      n_fail++; $display("FAIL hs_accepted: pushes=%0d expected 2", pushes);
    end
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL hs_full: in_ready=%b expected 0", in_ready);
    end
    goto_edge(32);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL hs_after_pop: in_ready=%b expected 1", in_ready);
    end
    goto_edge(33);
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL hs_refill: in_ready=%b expected 0", in_ready);
    end
    // Sample 0 (I rail) reaches out at edge 37 on phase 0.
    goto_edge(37);
    n_tests++;
    if (out !== 16'h8001) begin
      n_fail++; $display("FAIL hs_order_i: out=%h expected 8001", out);
    end
    // Q rail must still be silent: sample 1 is not popped until edge 64.
    goto_edge(38);
    n_tests++;
    if (out !== 16'h8000) begin
      n_fail++; $display("FAIL hs_order_q_early: out=%h expected 8000", out);
    end
    // Sample 1 popped at 64: Q rail trims to 3 after edge 69, shown as -3 on phase 1.
    goto_edge(70);
    n_tests++;
    if (out !== 16'h7FFD) begin
      n_fail++; $display("FAIL hs_order_q: out=%h expected 7ffd", out);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_underflow();
    apply_reset();
    in_i     = 16'sd1024;
    in_q     = 16'sd0;
    in_valid = 1'b1;
    adv(1);
    in_valid = 1'b0;
    in_i     = '0;
    goto_edge(32);
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL uf_e32: out_underflow=%b expected 0", out_underflow);
    end
    goto_edge(63);
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL uf_e63: out_underflow=%b expected 0", out_underflow);
    end
    goto_edge(64);
    n_tests++;
    if (out_underflow !== 1'b1) begin
      n_fail++; $display("FAIL uf_e64: out_underflow=%b expected 1", out_underflow);
    end
    goto_edge(65);
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL uf_e65: out_underflow=%b expected 0", out_underflow);
    end
    goto_edge(96);
    n_tests++;
    if (out_underflow !== 1'b1) begin
      n_fail++; $display("FAIL uf_e96: out_underflow=%b expected 1", out_underflow);
    end
    // Finite impulse response has fully decayed well before edge 200.
    check_seq("uf_decay", 200, 203, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
  endtask

  task automatic test_impulse_latency();
    apply_reset();
    in_i     = 16'sd1024;
    in_q     = 16'sd0;
    in_valid = 1'b1;
    adv(1);
    in_valid = 1'b0;
    in_i     = '0;
    goto_edge(36);
    n_tests++;
    if (out !== 16'h8000) begin
      n_fail++; $display("FAIL lat_early: out=%h expected 8000", out);
    end
    goto_edge(37);
    n_tests++;
    if (out !== 16'h8001) begin
      n_fail++; $display("FAIL lat_first: out=%h expected 8001", out);
    end
  endtask

  // Full-scale negative I held long enough for the trim to reach -32768 exactly,
  // so the phase-2 negation must clip to +32767 (FFFF) instead of wrapping (0000).
  task automatic test_saturation();
    apply_reset();
    in_i     = 16'sh8000;
    in_q     = 16'sd0;
    in_valid = 1'b1;
    check_seq("sat", 140, 143, SAT_SEQ[0], SAT_SEQ[1], SAT_SEQ[2], SAT_SEQ[3]);
    in_valid = 1'b0;
    in_i     = '0;
  endtask

  task automatic test_reset_midop();
    apply_reset();
    in_i     = 16'sd1000;
    in_q     = 16'sd0;
    in_valid = 1'b1;
    goto_edge(100);
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (out !== 16'h8000) begin
      n_fail++; $display("FAIL midrst_out: out=%h expected 8000", out);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL midrst_ready: in_ready=%b expected 1", in_ready);
    end
    n_tests++;
    if (out_underflow !== 1'b0) begin
      n_fail++; $display("FAIL midrst_uf: out_underflow=%b expected 0", out_underflow);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset  = 1'b1;
    edge_n = 0;
    // Buffered samples were discarded, so the first tick underflows.
    goto_edge(32);
    n_tests++;
    if (out_underflow !== 1'b1) begin
      n_fail++; $display("FAIL midrst_fifo_cleared: out_underflow=%b expected 1", out_underflow);
    end
    // Cleared CIC state: the I-rail phases stay at midscale.
    check_seq("midrst_cic", 41, 43, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
  endtask

  initial begin
    test_reset();
    test_dc_i();
    test_dc_q();
    test_handshake();
    test_underflow();
    test_impulse_latency();
    test_saturation();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
